// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths, depth
// derivation and the write-port priority resolver used by array update and bypass.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int ZERO_ADDR  = 0;
    // Upper bound on write ports handled by the priority resolver.
    localparam int MAX_WR     = 8;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One-hot of the highest-index matching write port; all zero when none match.
    function automatic logic [MAX_WR-1:0] win_port(input logic [MAX_WR-1:0] match);
        logic [MAX_WR-1:0] oh;
        oh = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (match[j]) begin
                oh    = '0;
                oh[j] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: per-register pend bits, incremental pending count
// and registered busy flags for the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] wr_mask;
    logic [DEPTH-1:0] rsv_mask;
    logic [DEPTH-1:0] pend_nxt;
    logic [DEPTH-1:0] clr;
    logic [CNT_W-1:0] dec;
    logic [CNT_W-1:0] cnt_nxt;

    // Writes clear first, then the reservation sets, so a same-cycle reserve wins.
    always_comb begin
        wr_mask  = '0;
        rsv_mask = '0;
        dec      = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                wr_mask[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (rsv_en && !(ZERO_REG != 0 && rsv_addr == ADDR_W'(ZERO_ADDR))) begin
            rsv_mask[rsv_addr] = 1'b1;
        end
        pend_nxt = (pend & ~wr_mask) | rsv_mask;
        clr      = pend & wr_mask & ~rsv_mask;
        for (int a = 0; a < DEPTH; a++) begin
            dec = dec + CNT_W'(clr[a]);
        end
        cnt_nxt = pend_cnt + CNT_W'(|(rsv_mask & ~pend)) - dec;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
            rd_busy  <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
            for (int k = 0; k < NUM_RD; k++) begin
                rd_busy[k] <= pend_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write-to-read bypass,
// prioritised write ports, optional zero register and pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem  [DEPTH];
    logic [MAX_WR-1:0] wsel [DEPTH];
    logic [DATA_W-1:0] wval [DEPTH];
    logic [DATA_W-1:0] rval [NUM_RD];

    // Per-address winning write port and its data; shared by array update and bypass.
    always_comb begin
        logic [MAX_WR-1:0] match;
        for (int a = 0; a < DEPTH; a++) begin
            match = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                match[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a));
            end
            wsel[a] = win_port(match);
            wval[a] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wsel[a][j]) begin
                    wval[a] = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (ZERO_REG != 0 && ra == ADDR_W'(ZERO_ADDR)) begin
                rval[k] = '0;
            end else if (|wsel[ra]) begin
                rval[k] = wval[ra];
            end else begin
                rval[k] = mem[ra];
            end
        end
    end

    // NOTE: the array has a synchronous clear because architectural state must
    // read zero after reset; this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
            rd_data <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (|wsel[a] && !(ZERO_REG != 0 && a == ZERO_ADDR)) begin
                    mem[a] <= wval[a];
                end
            end
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data[k*DATA_W +: DATA_W] <= rval[k];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [AW:0]      pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural registers and pending flags.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];

    regfile_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .NUM_WR (NW), .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    // Apply current inputs for one edge, advance the model, then compare outputs.
    task automatic step(input logic r);
        logic [DW-1:0] exp_d;
        int            exp_cnt;
        int            a;
        rst = r;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                a = int'(wr_addr[j*AW +: AW]);
                if (wr_en[j] && a != 0) m_regs[a] = wr_data[j*DW +: DW];
            end
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j]) m_pend[int'(wr_addr[j*AW +: AW])] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[int'(rsv_addr)] = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) exp_cnt += int'(m_pend[i]);
        for (int k = 0; k < NR; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            exp_d = (r || a == 0) ? '0 : m_regs[a];
            check($sformatf("rd_data[%0d]", k), 64'(rd(k)), 64'(exp_d));
            check($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), r ? 64'd0 : 64'(m_pend[a]));
        end
        check("pend_cnt", 64'(pend_cnt), 64'(exp_cnt));
        rst = 1'b0;
    endtask

    // Idle lanes carry random garbage so disabled ports are proven inert.
    task automatic idle();
        wr_en    = '0;
        rsv_en   = 1'b0;
        wr_addr  = NW*AW'($urandom);
        wr_data  = {$urandom, $urandom};
        rsv_addr = AW'($urandom);
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        wr_en[j]            = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        step(1'b1);
        check("reset_cnt", 64'(pend_cnt), 64'd0);

        // Every register reads zero and idle after reset.
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a, DEPTH - 1 - a);
            step(1'b0);
        end

        // Same-cycle write and read returns the new data via bypass.
        idle(); set_wr(0, 3, 32'h1234); set_rd(3, 0);
        step(1'b0);
        check("bypass_r3", 64'(rd(0)), 64'h1234);
        idle(); set_rd(1, 2); step(1'b0);
        idle(); set_rd(3, 3); step(1'b0);
        check("stored_r3", 64'(rd(0)), 64'h1234);

        // Highest-index port wins a collision; zero register stays zero.
        idle(); set_wr(0, 5, 32'hAAAA); set_wr(1, 5, 32'h5555); set_rd(5, 5);
        step(1'b0);
        check("prio_bypass_r5", 64'(rd(1)), 64'h5555);
        idle(); set_rd(5, 4); step(1'b0);
        check("prio_r5", 64'(rd(0)), 64'h5555);
        idle(); set_wr(0, 0, 32'hFFFF); set_rd(0, 0); step(1'b0);
        check("zero_bypass", 64'(rd(0)), 64'h0);
        idle(); set_rd(0, 0); step(1'b0);
        check("zero_r0", 64'(rd(1)), 64'h0);

        // Reservation on r7, then a same-cycle write+reserve, then the writeback.
        idle(); rsv_en = 1'b1; rsv_addr = 4'd7; set_rd(7, 7); step(1'b0);
        check("rsv7_cnt", 64'(pend_cnt), 64'd1);
        check("rsv7_busy", 64'(rd_busy[0]), 64'd1);
        idle(); rsv_en = 1'b1; rsv_addr = 4'd7; set_wr(1, 7, 32'h77); set_rd(7, 7); step(1'b0);
        check("rsv_wr7_cnt", 64'(pend_cnt), 64'd1);
        check("rsv_wr7_busy", 64'(rd_busy[1]), 64'd1);
        idle(); set_wr(0, 7, 32'h777); set_rd(7, 7); step(1'b0);
        check("wb7_cnt", 64'(pend_cnt), 64'd0);
        check("wb7_busy", 64'(rd_busy[0]), 64'd0);
        idle(); rsv_en = 1'b1; rsv_addr = 4'd0; step(1'b0);
        check("rsv_r0_cnt", 64'(pend_cnt), 64'd0);

        // Count climbs 1, 2, 3 and drops to 1 after a dual writeback.
        for (int i = 1; i <= 3; i++) begin
            idle(); rsv_en = 1'b1; rsv_addr = AW'(i); set_rd(i, 1); step(1'b0);
            check("rsv_seq_cnt", 64'(pend_cnt), 64'(i));
        end
        idle(); rsv_en = 1'b1; rsv_addr = 4'd3; step(1'b0);
        check("rersv_cnt", 64'(pend_cnt), 64'd3);
        idle(); set_wr(0, 1, 32'h11); set_wr(1, 2, 32'h22); set_rd(1, 2); step(1'b0);
        check("dual_wb_cnt", 64'(pend_cnt), 64'd1);

        // Reset with four pending registers and live writes discards everything.
        for (int i = 4; i <= 6; i++) begin
            idle(); rsv_en = 1'b1; rsv_addr = AW'(i); step(1'b0);
        end
        check("pre_rst_cnt", 64'(pend_cnt), 64'd4);
        idle(); set_wr(0, 9, 32'h9999); set_wr(1, 3, 32'h3333); rsv_en = 1'b1; rsv_addr = 4'd10;
        set_rd(9, 3); step(1'b1);
        check("rst_cnt", 64'(pend_cnt), 64'd0);
        check("rst_busy", 64'(rd_busy), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        idle(); set_rd(9, 3); step(1'b0);
        check("rst_drop_wr", 64'(rd(0)), 64'd0);

        // Randomized traffic, often colliding on a small address range.
        for (int n = 0; n < 3000; n++) begin
            int span;
            span     = ($urandom_range(0, 1) == 0) ? 3 : DEPTH - 1;
            wr_en    = NW'($urandom);
            wr_data  = {$urandom, $urandom};
            for (int j = 0; j < NW; j++) wr_addr[j*AW +: AW] = AW'($urandom_range(0, span));
            rsv_en   = 1'($urandom);
            rsv_addr = AW'($urandom_range(0, span));
            set_rd($urandom_range(0, span), $urandom_range(0, span));
            step($urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the CPU datapath. It replaces the single-write, two-read combinational register array.
- Synchronous reads with write-to-read bypass.
- Multiple write ports with a fixed priority order.
- Optional hardwired zero register.
- Per-register pending scoreboard so issue logic can detect RAW hazards on outstanding writebacks.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register index width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 always reads 0, and writes/reservations to it are ignored

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, registered
rd_busy  output  NUM_RD  registered pending bit of the register addressed on each read port
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  packed write addresses
wr_data  input  NUM_WR*DATA_W  packed write data
rsv_en  input  1  reserve destination (instruction issued, writeback outstanding)
rsv_addr  input  ADDR_W  register to mark pending
pend_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: on a rising edge with rst=1, the following are cleared, and all other inputs that cycle are ignored:
  - all DEPTH registers = 0
  - all pending bits = 0
  - rd_data = 0, rd_busy = 0, pend_cnt = 0
- Reset asserted mid-operation discards in-flight writes and reservations the same cycle.
- Write:
  - On each edge, every port j with wr_en[j]=1 writes wr_data[j] to wr_addr[j].
  - If several ports target the same address, the highest-index port wins.
  - If ZERO_REG=1 and the address is 0, the write is dropped.
- Read, 1-cycle latency: rd_data[k] at edge n+1 reflects rd_addr[k] sampled at edge n.
- Bypass:
  - If an enabled write targets rd_addr[k] in the same cycle, rd_data[k] returns the winning write data, not the stale array value.
  - If ZERO_REG=1 and rd_addr[k]=0, rd_data[k] = 0 regardless of writes.
- Scoreboard state and update order:
  - pend[DEPTH] is a 1-bit register per entry.
  - Each edge, first clear pend[wr_addr[j]] for every enabled write port j.
  - Then set pend[rsv_addr] if rsv_en=1.
  - Reserve and write on the same address in the same cycle leaves the bit set: the new instruction's reservation wins.
  - rsv_en to register 0 with ZERO_REG=1 is ignored.
  - Re-reserving an already pending register leaves it set, with no count change.
  - A write to a non-pending register is legal and leaves the bit at 0.
- rd_busy:
  - rd_busy[k] at edge n+1 = the post-update value of pend[rd_addr[k]] at edge n.
  - It therefore includes same-cycle reserves and clears.
- pend_cnt:
  - Registered population count of pend after the update.
  - Maintained incrementally: +1 if the reserve sets a previously clear bit; -1 per distinct previously set address cleared by a write and not re-reserved.
  - Must always equal popcount(pend); saturation is impossible by construction, max DEPTH.
- No X propagation: unused port lanes with wr_en=0 must not affect state.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults
  - the DEPTH derivation
  - the ZERO address constant
  - a function resolving the winning write port for an address, used by both array update and bypass
- Natural sub-module: regfile_scoreboard, holding the pend array, pend_cnt and rd_busy generation.
- The data array and bypass stay in regfile_mp.

Test Plan:
- Reset then read all 16 regs on both ports -> rd_data = 0 and rd_busy = 0 one cycle after each address; pend_cnt = 0.
- wr0 r3=0x1234 and rd0 addr 3 in the same cycle -> next cycle rd_data[0] = 0x1234 (bypass); a read two cycles later also gives 0x1234.
- wr0 r5=0xAAAA and wr1 r5=0x5555 simultaneously -> r5 reads 0x5555; wr0 r0=0xFFFF with ZERO_REG=1 -> r0 reads 0.
- rsv r7 -> pend_cnt = 1, rd_busy for r7 = 1. Then wr r7 and rsv r7 in the same cycle -> still busy, pend_cnt = 1. Then wr r7 only -> busy 0, pend_cnt = 0.
- Reserve r1, r2, r3 on consecutive cycles, then write r1 and r2 on the two ports in one cycle -> pend_cnt goes 1, 2, 3, then 1.
- Assert rst with 4 pending registers and writes active -> next cycle all data 0, pend_cnt 0, rd_busy 0; that cycle's write is not applied.
